// File: rtl/hex_sector_streamer.sv
// HEX load sequencer: SD sector reads into the shared buffer, then
// preamble + buffer bytes streamed to the bootloader UART.
//
// Ports:
//   clk_100m, reset_n      clock, synchronous active-low reset
//   start, abort           begin a load / cancel it (abort wins)
//   busy, done, overflow   load status; overflow is sticky until start
//   sd_lba, sd_rd, sd_ack  sector request handshake with hps_io
//   buf_addr, buf_dout     sector buffer read port (1-cycle latency)
//   tx_data/valid/ready    byte stream to the UART transmitter
//   progress               saturating count of bytes transmitted
module hex_sector_streamer #(
    parameter int         PREAMBLE_LEN = 10,
    parameter logic [7:0] EOF_BYTE     = 8'h1A,
    parameter int         LBA_W        = 9,
    parameter int         MAX_SECTORS  = 511
) (
    input  logic             clk_100m,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    input  logic             sd_ack,
    output logic [8:0]       buf_addr,
    input  logic [7:0]       buf_dout,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [17:0]      progress
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SD_REQ,
        S_SD_FILL,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_FIN
    } state_t;

    localparam logic [7:0] PRE_LAST =
        8'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
    localparam logic [LBA_W-1:0] LBA_LIMIT = LBA_W'(MAX_SECTORS);

    state_t           state;
    logic [7:0]       pre_idx;
    logic             xfer;
    logic [LBA_W-1:0] lba_next;
    logic [17:0]      progress_inc;

    assign xfer         = tx_valid && tx_ready;
    assign lba_next     = sd_lba + LBA_W'(1);
    assign progress_inc = (progress == '1) ? progress : progress + 18'd1;

    // buf_addr doubles as the byte index: it is presented during FETCH
    // so buf_dout is valid in LATCH.
    always_ff @(posedge clk_100m) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pre_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            sd_lba   <= '0;
            sd_rd    <= 1'b0;
            buf_addr <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            progress <= '0;
        end else if (abort && state != S_IDLE) begin
            state    <= S_IDLE;
            sd_rd    <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        busy     <= 1'b1;
                        sd_lba   <= '0;
                        buf_addr <= '0;
                        pre_idx  <= '0;
                        progress <= '0;
                        overflow <= 1'b0;
                        if (PREAMBLE_LEN > 0) begin
                            state    <= S_PRE;
                            tx_data  <= 8'h30;
                            tx_valid <= 1'b1;
                        end else begin
                            state <= S_SD_REQ;
                            sd_rd <= 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    if (xfer) begin
                        progress <= progress_inc;
                        pre_idx  <= pre_idx + 8'd1;
                        if (pre_idx == PRE_LAST) begin
                            tx_valid <= 1'b0;
                            sd_rd    <= 1'b1;
                            state    <= S_SD_REQ;
                        end else begin
                            tx_data <= 8'h30 + pre_idx + 8'd1;
                        end
                    end
                end
                S_SD_REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        state <= S_SD_FILL;
                    end
                end
                S_SD_FILL: begin
                    if (!sd_ack) begin
                        buf_addr <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    if (buf_dout == EOF_BYTE) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end else begin
                        tx_data  <= buf_dout;
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        progress <= progress_inc;
                        if (buf_addr != 9'h1FF) begin
                            buf_addr <= buf_addr + 9'd1;
                            state    <= S_FETCH;
                        end else begin
                            buf_addr <= '0;
                            sd_lba   <= lba_next;
                            if (lba_next == LBA_LIMIT) begin
                                overflow <= 1'b1;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= S_FIN;
                            end else begin
                                sd_rd <= 1'b1;
                                state <= S_SD_REQ;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_sector_streamer.sv
// Scoreboard bench for hex_sector_streamer: SD/hps_io and buffer model,
// randomized UART backpressure, stream model built from sector images.
module tb_hex_sector_streamer;

    localparam int PRE     = 10;
    localparam int MAXS    = 2;
    localparam int ACK_LEN = 520;
    localparam logic [7:0] EOFB = 8'h1A;

    logic        clk_100m = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [8:0]  sd_lba;
    logic        sd_rd;
    logic        sd_ack;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [17:0] progress;

    hex_sector_streamer #(
        .PREAMBLE_LEN(PRE),
        .EOF_BYTE(EOFB),
        .LBA_W(9),
        .MAX_SECTORS(MAXS)
    ) dut (
        .clk_100m(clk_100m),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .sd_lba(sd_lba),
        .sd_rd(sd_rd),
        .sd_ack(sd_ack),
        .buf_addr(buf_addr),
        .buf_dout(buf_dout),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .progress(progress)
    );

    always #5 clk_100m = ~clk_100m;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sd_img [0:MAXS-1][0:511];
    logic [7:0] buffer [0:511];

    logic [7:0] exp_q[$];
    int         lba_q[$];
    int         rqp_q[$];
    bit         exp_ovf;
    int         exp_prog;

    int  done_cnt = 0;
    int  d0;
    bit  rdy_rand = 1'b0;
    bit  hold_low = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // sector buffer: registered read
    always @(posedge clk_100m) buf_dout <= buffer[buf_addr];

    // hps_io: after a request, ack high for ACK_LEN cycles while filling
    initial begin
        sd_ack = 1'b0;
        for (int i = 0; i < 512; i++) buffer[i] = 8'h00;
        forever begin
            @(negedge clk_100m);
            if (sd_rd) begin
                repeat ($urandom_range(1, 4)) @(posedge clk_100m);
                #1;
                sd_ack = 1'b1;
                if (int'(sd_lba) < MAXS)
                    for (int i = 0; i < 512; i++)
                        buffer[i] = sd_img[int'(sd_lba)][i];
                repeat (ACK_LEN) @(posedge clk_100m);
                #1;
                sd_ack = 1'b0;
            end
        end
    end

    // UART ready
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk_100m);
            #2;
            if (hold_low)      tx_ready = 1'b0;
            else if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
            else               tx_ready = 1'b1;
        end
    end

    // monitor
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    bit         prev_rd = 1'b0;
    always @(negedge clk_100m) begin
        if (reset_n) begin
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0)
                    check("tx_extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
            if (prev_stall) begin
                check("bp_valid_held", {31'h0, tx_valid}, 32'd1);
                check("bp_data_held", {24'h0, tx_data}, {24'h0, prev_data});
            end
            if (sd_rd && !prev_rd) begin
                if (lba_q.size() == 0) begin
                    check("sd_rd_extra", {23'h0, sd_lba}, 32'hFFFF_FFFF);
                end else begin
                    check("sd_lba", {23'h0, sd_lba}, lba_q.pop_front());
                    check("req_progress", {14'h0, progress}, rqp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", {31'h0, busy}, 32'd0);
            end
        end
        prev_stall = reset_n && tx_valid && !tx_ready && !abort;
        prev_data  = tx_data;
        prev_rd    = sd_rd;
    end

    // reference: stream = preamble, then sector bytes up to EOF
    task automatic build_expect();
        int  data;
        bit  stop;
        data = 0;
        stop = 1'b0;
        exp_q.delete();
        lba_q.delete();
        rqp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'(8'h30 + i));
        for (int s = 0; s < MAXS && !stop; s++) begin
            lba_q.push_back(s);
            rqp_q.push_back(PRE + data);
            for (int i = 0; i < 512 && !stop; i++) begin
                if (sd_img[s][i] == EOFB) stop = 1'b1;
                else begin
                    exp_q.push_back(sd_img[s][i]);
                    data++;
                end
            end
            if (!stop && s == MAXS - 1) exp_ovf = 1'b1;
        end
        exp_prog = PRE + data;
    endtask

    task automatic fill_img(input int eof_sec, input int eof_idx);
        logic [7:0] b;
        for (int s = 0; s < MAXS; s++)
            for (int i = 0; i < 512; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == EOFB) b = 8'h1B;
                sd_img[s][i] = b;
            end
        if (eof_sec >= 0) sd_img[eof_sec][eof_idx] = EOFB;
    endtask

    task automatic pulse_start();
        @(posedge clk_100m);
        #1 start = 1'b1;
        @(posedge clk_100m);
        #1 start = 1'b0;
    endtask

    task automatic start_load();
        build_expect();
        d0 = done_cnt;
        pulse_start();
    endtask

    task automatic finish_load(input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(negedge clk_100m);
            n++;
        end
        if (done_cnt == d0) fail({tag, "_done_timeout"});
        repeat (3) @(negedge clk_100m);
        check({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_overflow"}, {31'h0, overflow}, {31'h0, exp_ovf});
        check({tag, "_progress"}, {14'h0, progress}, exp_prog);
        check({tag, "_bytes_left"}, exp_q.size(), 32'd0);
        check({tag, "_reqs_left"}, lba_q.size(), 32'd0);
        check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] cap;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        fill_img(0, 3);
        repeat (3) @(negedge clk_100m);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        check("rst_sd_rd", {31'h0, sd_rd}, 32'd0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        check("rst_sd_lba", {23'h0, sd_lba}, 32'd0);
        check("rst_buf_addr", {23'h0, buf_addr}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'd0);
        check("rst_progress", {14'h0, progress}, 32'd0);
        @(posedge clk_100m);
        #1 reset_n = 1'b1;

        // preamble then 3 data bytes, EOF at index 3
        sd_img[0][0] = 8'h3A;
        sd_img[0][1] = 8'h31;
        sd_img[0][2] = 8'h30;
        sd_img[0][3] = EOFB;
        rdy_rand = 1'b0;
        start_load();
        @(negedge clk_100m);
        check("busy_after_start", {31'h0, busy}, 32'd1);
        finish_load("eof3");
        check("eof3_progress_13", {14'h0, progress}, 32'd13);

        // two sectors, EOF at sector 1 index 5, with a 37-cycle stall
        fill_img(1, 5);
        rdy_rand = 1'b1;
        start_load();
        n = 0;
        while (progress < 18'd100 && n < 8000) begin
            @(negedge clk_100m);
            n++;
        end
        if (progress < 18'd100) fail("bp_progress_timeout");
        hold_low = 1'b1;
        repeat (3) @(negedge clk_100m);
        check("bp_valid_early", {31'h0, tx_valid}, 32'd1);
        cap = tx_data;
        repeat (34) @(negedge clk_100m);
        check("bp_valid_late", {31'h0, tx_valid}, 32'd1);
        check("bp_data_late", {24'h0, tx_data}, {24'h0, cap});
        hold_low = 1'b0;
        finish_load("multi");
        check("multi_progress_527", {14'h0, progress}, 32'd527);

        // no EOF anywhere: overflow after MAXS sectors
        fill_img(-1, 0);
        rdy_rand = 1'b0;
        start_load();
        finish_load("ovf");
        check("ovf_progress_1034", {14'h0, progress}, 32'd1034);

        // abort during SD_FILL
        fill_img(0, 40);
        rdy_rand = 1'b1;
        start_load();
        n = 0;
        while (!sd_ack && n < 500) begin
            @(negedge clk_100m);
            n++;
        end
        if (!sd_ack) fail("abort_ack_timeout");
        repeat (5) @(negedge clk_100m);
        check("ovf_cleared_by_start", {31'h0, overflow}, 32'd0);
        @(posedge clk_100m);
        #1 abort = 1'b1;
        @(posedge clk_100m);
        #1 abort = 1'b0;
        @(negedge clk_100m);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_sd_rd", {31'h0, sd_rd}, 32'd0);
        check("abort_tx_valid", {31'h0, tx_valid}, 32'd0);
        n = 0;
        while (sd_ack && n < 1000) begin
            @(negedge clk_100m);
            n++;
        end
        if (sd_ack) fail("abort_ack_fall_timeout");
        repeat (5) @(negedge clk_100m);
        check("abort_no_done", done_cnt, d0);
        @(posedge clk_100m);
        #1 begin abort = 1'b1; start = 1'b1; end
        @(posedge clk_100m);
        #1 begin abort = 1'b0; start = 1'b0; end
        @(negedge clk_100m);
        check("abort_beats_start", {31'h0, busy}, 32'd0);
        repeat (2) @(negedge clk_100m);
        check("abort_pair_sd_rd", {31'h0, sd_rd}, 32'd0);

        // restart from preamble; extra start while busy is ignored
        start_load();
        repeat (25) @(negedge clk_100m);
        pulse_start();
        finish_load("restart");

        // random images and random backpressure
        for (int r = 0; r < 3; r++) begin
            if ($urandom_range(0, 3) == 0) fill_img(-1, 0);
            else fill_img(int'($urandom_range(0, MAXS - 1)),
                          int'($urandom_range(0, 511)));
            start_load();
            finish_load("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hex_sector_streamer.md
Name: hex_sector_streamer

Overview:
- Sequences the HEX-file load path: requests 512-byte sectors from the HPS SD interface into the shared sector buffer, then streams each byte to the UART transmitter feeding the bootloader.
- Emits an ASCII sync preamble first, stops on the end-of-file byte, and reports progress for the loading screen.
- Owns the buffer read port and sd_rd/sd_lba while busy. When idle it releases them to the emulated system.

Parameters:
- PREAMBLE_LEN, 10, number of preamble bytes sent before sector 0; byte i = 8'h30 + i.
- EOF_BYTE, 8'h1A, byte value that terminates the stream; it is not transmitted.
- LBA_W, 9, width of sd_lba and of the sector counter.
- MAX_SECTORS, 511, sector limit; reaching it without EOF ends the stream with an error.

Ports:
- clk_100m  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load (status[0] edge)
- abort  in  1  level; cancels the load
- busy  out  1  high from start through DONE
- done  out  1  one-cycle pulse when the stream ends (EOF or overflow)
- overflow  out  1  sticky; set when MAX_SECTORS is reached; cleared by start
- sd_lba  out  LBA_W  sector currently requested
- sd_rd  out  1  sector read request to hps_io
- sd_ack  in  1  hps_io transfer acknowledge (high during buffer fill)
- buf_addr  out  9  buffer read address
- buf_dout  in  8  buffer read data; valid one cycle after buf_addr
- tx_data  out  8  byte to UART
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART can accept
- progress  out  18  total bytes transmitted, including preamble (drives busy-screen colour)

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Outputs: busy=0, done=0, overflow=0, sd_rd=0, tx_valid=0, sd_lba=0, buf_addr=0, tx_data=0, progress=0.
  - State: IDLE.
- States: IDLE, PRE, SD_REQ, SD_FILL, FETCH, LATCH, SEND, FIN.
- IDLE:
  - start=1 → PRE. Clear sd_lba, byte index, preamble index, progress and overflow. Set busy=1 on the next cycle.
  - start while busy is ignored.
- PRE:
  - Drive tx_data = 8'h30 + idx with tx_valid=1.
  - A transfer completes on any cycle with tx_valid && tx_ready. On transfer: idx++, progress++.
  - After byte PREAMBLE_LEN-1 is transferred → SD_REQ. PREAMBLE_LEN=0 goes straight to SD_REQ.
- SD_REQ: assert sd_rd with sd_lba stable. Hold sd_rd until sd_ack is sampled high, then deassert sd_rd → SD_FILL.
- SD_FILL: wait for sd_ack low (buffer filled) → FETCH with byte index 0.
- FETCH: buf_addr = byte index → LATCH. This covers the 1-cycle buffer read latency.
- LATCH: register buf_dout.
  - buf_dout == EOF_BYTE → FIN; nothing is sent.
  - Otherwise tx_data <= buf_dout, tx_valid <= 1 → SEND.
- SEND:
  - Hold tx_valid and tx_data stable until tx_ready. On transfer: tx_valid=0, progress++.
  - Byte index < 511 → index+1, FETCH.
  - Byte index == 511 → index wraps to 0 and sd_lba++:
    - new sd_lba == MAX_SECTORS → overflow=1, FIN;
    - else → SD_REQ.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle → IDLE.
- tx_valid is only deasserted after a transfer, except on abort or reset.
- abort=1 in any non-IDLE state → IDLE on the next edge.
  - sd_rd=0, tx_valid=0, busy=0. No done pulse; overflow is unchanged.
  - An in-flight sd_ack is ignored. The hps_io transfer still completes into the buffer.
- abort and start in the same cycle: abort wins; stay in IDLE.
- When busy=0, buf_addr is don't-care; the top level muxes it away.
- progress saturates at 2^18-1.
- Reset mid-operation has the same effect as abort, plus all outputs return to their reset values.
- Throughput: one data byte per 3 cycles when tx_ready is held high (FETCH, LATCH, SEND).

Test Plan:
- Preamble: reset, start, tx_ready tied 1 → bytes 0x30..0x39 transferred, then sd_rd rises with sd_lba=0, progress=10.
- Single sector with EOF: model sd_ack (high 520 cycles, then low); buffer holds 0x3A,0x31,0x30 at 0..2 and 0x1A at 3 → exactly 3 data bytes sent, done pulses once, busy falls, overflow=0, progress=13.
- Multi-sector: sector 0 has no EOF, sector 1 has EOF at index 5 → 512+5 data bytes sent, second sd_rd carries sd_lba=1, progress=527.
- Backpressure: tx_ready low for 37 cycles mid-byte → tx_valid stays high and tx_data unchanged throughout; no byte lost or duplicated.
- Overflow: MAX_SECTORS=2, no EOF byte anywhere → after 1024 data bytes overflow=1, done pulses, no third sd_rd.
- Abort/restart: abort during SD_FILL → busy=0 next cycle, no done pulse. A subsequent start restarts from preamble with sd_lba=0. A start pulse issued while busy has no effect.
